// File: rtl/graph_mem_arbiter_if.sv
// Bus bundle between the graph fetch unit / graph BRAM and graph_mem_arbiter.
// master = requester + memory side, slave = arbiter.
interface graph_mem_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_valid_in;
  logic [32*NUM_REQ-1:0] req_addr_in;
  logic [NUM_REQ-1:0]    req_ready_out;
  logic [NUM_REQ-1:0]    resp_valid_out;
  logic [31:0]           resp_data_out;
  logic                  mem_en_out;
  logic [31:0]           mem_addr_out;
  logic [31:0]           mem_data_in;
  logic [NUM_REQ-1:0]    overflow_out;
  logic                  busy_out;

  modport master (
    output req_valid_in, req_addr_in, mem_data_in,
    input  req_ready_out, resp_valid_out, resp_data_out,
           mem_en_out, mem_addr_out, overflow_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_addr_in, mem_data_in,
    output req_ready_out, resp_valid_out, resp_data_out,
           mem_en_out, mem_addr_out, overflow_out, busy_out
  );
endinterface

// File: rtl/graph_mem_arbiter.sv
// Shares one graph BRAM read port among NUM_REQ queued read streams.
// Define GRAPH_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module graph_mem_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int QDEPTH   = 2,
  parameter int READ_LAT = 2
) (
  input logic                clk_in,
  input logic                rst_in,
  graph_mem_arbiter_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(QDEPTH);

  logic [NUM_REQ-1:0]       w_nonempty, w_nxt_busy, w_gnt, w_ovf, w_rdy;
  logic [NUM_REQ-1:0][31:0] w_head;
  logic                     w_any_gnt;
  logic [IW-1:0]            w_gnt_idx;

  // vld_pipe[0] is the BRAM enable; stage READ_LAT lines up with mem_data_in
  logic [READ_LAT:0]         r_vld_pipe;
  logic [READ_LAT:0][IW-1:0] r_idx_pipe;
  logic [31:0]               r_mem_addr, r_resp_data;
  logic [NUM_REQ-1:0]        r_resp_vld;
  logic                      r_busy;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_q
    logic [QDEPTH-1:0][31:0] r_mem;
    logic [PW-1:0]           r_wp, r_rp;
    logic [PW:0]             r_cnt;
    logic                    r_ovf, r_rdy;
    logic                    w_full, w_push;
    logic [PW:0]             w_cnt_nxt;

    // a full queue still accepts when its head leaves in the same cycle
    assign w_full        = (r_cnt == CNT_FULL);
    assign w_push        = bus.req_valid_in[i] & (~w_full | w_gnt[i]);
    assign w_cnt_nxt     = r_cnt + (PW+1)'(w_push) - (PW+1)'(w_gnt[i]);
    assign w_nonempty[i] = (r_cnt != '0);
    assign w_nxt_busy[i] = (w_cnt_nxt != '0);
    assign w_head[i]     = r_mem[r_rp];
    assign w_ovf[i]      = r_ovf;
    assign w_rdy[i]      = r_rdy;

    always_ff @(posedge clk_in)
      if (w_push) r_mem[r_wp] <= bus.req_addr_in[32*i +: 32];

    always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
        r_wp  <= '0;
        r_rp  <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
        r_rdy <= 1'b1;
      end else begin
        if (w_push)   r_wp <= r_wp + 1'b1;
        if (w_gnt[i]) r_rp <= r_rp + 1'b1;
        r_cnt <= w_cnt_nxt;
        r_rdy <= (w_cnt_nxt != CNT_FULL);
        if (bus.req_valid_in[i] && !w_push) r_ovf <= 1'b1;
      end
    end
  end

`ifdef GRAPH_ARB_FIXED_PRIO_EN
  always_comb begin
    w_any_gnt = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--)
      if (w_nonempty[k]) begin
        w_any_gnt = 1'b1;
        w_gnt_idx = IW'(k);
      end
  end
`else
  logic [IW-1:0] r_ptr;

  // scan from the far end so the candidate nearest the pointer is kept
  always_comb begin
    int idx;
    idx       = 0;
    w_any_gnt = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (w_nonempty[idx]) begin
        w_any_gnt = 1'b1;
        w_gnt_idx = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)        r_ptr <= '0;
    else if (w_any_gnt) r_ptr <= (w_gnt_idx == IW'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
  end
`endif

  always_comb begin
    w_gnt = '0;
    for (int k = 0; k < NUM_REQ; k++)
      w_gnt[k] = w_any_gnt && (w_gnt_idx == IW'(k));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_vld_pipe  <= '0;
      r_idx_pipe  <= '0;
      r_mem_addr  <= '0;
      r_resp_vld  <= '0;
      r_resp_data <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[READ_LAT-1:0], w_any_gnt};
      r_idx_pipe <= {r_idx_pipe[READ_LAT-1:0], w_gnt_idx};
      if (w_any_gnt) r_mem_addr <= w_head[w_gnt_idx];
      if (r_vld_pipe[READ_LAT]) begin
        r_resp_data <= bus.mem_data_in;
        r_resp_vld  <= NUM_REQ'(1) << r_idx_pipe[READ_LAT];
      end else begin
        r_resp_vld  <= '0;
      end
      r_busy <= (|w_nxt_busy) | w_any_gnt | (|r_vld_pipe[READ_LAT-1:0]);
    end
  end

  assign bus.req_ready_out  = w_rdy;
  assign bus.overflow_out   = w_ovf;
  assign bus.resp_valid_out = r_resp_vld;
  assign bus.resp_data_out  = r_resp_data;
  assign bus.mem_en_out     = r_vld_pipe[0];
  assign bus.mem_addr_out   = r_mem_addr;
  assign bus.busy_out       = r_busy;
endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Directed bench for graph_mem_arbiter: vector table plus fairness and mid-flight reset sequences.
module tb_graph_mem_arbiter;
  localparam int N = 3;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  graph_mem_arbiter_if #(.NUM_REQ(N)) bus ();

  graph_mem_arbiter #(.NUM_REQ(N), .QDEPTH(2), .READ_LAT(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  // BRAM model: data for the address presented with mem_en shows up two cycles later
  function automatic logic [31:0] bram(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0000_ABCD : (32'hD0D0_0000 | {16'h0, a[15:0]});
  endfunction

  logic [31:0] b_a1 = '0, b_a2 = '0;
  always @(posedge clk_in) begin
    b_a1 <= bus.mem_addr_out;
    b_a2 <= b_a1;
  end
  assign bus.mem_data_in = bram(b_a2);

  typedef struct {
    bit          rst;
    logic [2:0]  v;
    logic [31:0] a0, a1, a2;
    logic        en;
    logic [31:0] addr;
    logic [2:0]  rv;
    logic [31:0] rd;
    logic [2:0]  rdy, ovf;
    logic        busy;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit r, logic [2:0] v, logic [31:0] a0, a1, a2, logic en,
                              logic [31:0] addr, logic [2:0] rv, logic [31:0] rd,
                              logic [2:0] rdy, ovf, logic busy);
    vec_t t;
    t.rst = r; t.v = v; t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.en = en; t.addr = addr; t.rv = rv; t.rd = rd; t.rdy = rdy; t.ovf = ovf; t.busy = busy;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    bus.req_valid_in = '0;
    bus.req_addr_in  = '0;
    @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  // inputs change at negedge, outputs sampled 1ns after the following posedge
  task automatic drive(input logic [2:0] v, input logic [31:0] a0, a1, a2);
    @(negedge clk_in);
    bus.req_valid_in = v;
    bus.req_addr_in  = {a2, a1, a0};
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_all(input string p, input logic en, input logic [31:0] addr,
                         input logic [2:0] rv, input logic [31:0] rd,
                         input logic [2:0] rdy, ovf, input logic busy);
    chk({p, " mem_en"},   32'(bus.mem_en_out),     32'(en));
    chk({p, " mem_addr"}, bus.mem_addr_out,        addr);
    chk({p, " resp_vld"}, 32'(bus.resp_valid_out), 32'(rv));
    chk({p, " resp_dat"}, bus.resp_data_out,       rd);
    chk({p, " ready"},    32'(bus.req_ready_out),  32'(rdy));
    chk({p, " overflow"}, 32'(bus.overflow_out),   32'(ovf));
    chk({p, " busy"},     32'(bus.busy_out),       32'(busy));
  endtask

  initial begin
    bus.req_valid_in = '0;
    bus.req_addr_in  = '0;

    // single request from requester 1
    tbl.push_back(mk(1, 3'b010, 0, 32'h10, 0, 0, 32'h0,  3'b000, 32'h0,    3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,      1, 32'h10, 3'b000, 32'h0,    3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,      0, 32'h10, 3'b000, 32'h0,    3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,      0, 32'h10, 3'b000, 32'h0,    3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,      0, 32'h10, 3'b010, 32'hABCD, 3'b111, 3'b000, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,      0, 32'h10, 3'b000, 32'hABCD, 3'b111, 3'b000, 0));
    // all three requesters in the same cycle
    tbl.push_back(mk(1, 3'b111, 1, 2, 3, 0, 32'h0, 3'b000, 32'h0,   3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 32'h1, 3'b000, 32'h0,   3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 32'h2, 3'b000, 32'h0,   3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 1, 32'h3, 3'b000, 32'h0,   3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 32'h3, 3'b001, bram(1), 3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 32'h3, 3'b010, bram(2), 3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 32'h3, 3'b100, bram(3), 3'b111, 3'b000, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0, 0, 32'h3, 3'b000, bram(3), 3'b111, 3'b000, 0));
    // overflow: third of three back-to-back pulses to requester 1 is dropped (0xB4)
    tbl.push_back(mk(1, 3'b010, 0, 32'hB0, 0,          0, 32'h0,  3'b000, 32'h0,      3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,               1, 32'hB0, 3'b000, 32'h0,      3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b111, 32'hA2, 32'hB2, 32'hC2, 0, 32'hB0, 3'b000, 32'h0,     3'b111, 3'b000, 1));
    tbl.push_back(mk(0, 3'b010, 0, 32'hB3, 0,          1, 32'hC2, 3'b000, 32'h0,      3'b101, 3'b000, 1));
    tbl.push_back(mk(0, 3'b010, 0, 32'hB4, 0,          1, 32'hA2, 3'b010, bram(32'hB0), 3'b101, 3'b010, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,               1, 32'hB2, 3'b000, bram(32'hB0), 3'b111, 3'b010, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,               1, 32'hB3, 3'b100, bram(32'hC2), 3'b111, 3'b010, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,               0, 32'hB3, 3'b001, bram(32'hA2), 3'b111, 3'b010, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,               0, 32'hB3, 3'b010, bram(32'hB2), 3'b111, 3'b010, 1));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,               0, 32'hB3, 3'b010, bram(32'hB3), 3'b111, 3'b010, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,               0, 32'hB3, 3'b000, bram(32'hB3), 3'b111, 3'b010, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0, 0,               0, 32'hB3, 3'b000, bram(32'hB3), 3'b111, 3'b010, 0));

    // reset values while held in reset
    #12;
    chk_all("reset", 1'b0, 32'h0, 3'b000, 32'h0, 3'b111, 3'b000, 1'b0);
    rst_in = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].a2);
      chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].addr, tbl[i].rv, tbl[i].rd,
              tbl[i].rdy, tbl[i].ovf, tbl[i].busy);
    end

    // fairness / full-and-granted: requester 0 pulses every cycle, requester 2 once
    do_reset();
    for (int k = 0; k <= 10; k++) begin
      logic [2:0]  v;
      logic [31:0] ea;
      logic        een;
      v   = ((k < 8) ? 3'b001 : 3'b000) | ((k == 1) ? 3'b100 : 3'b000);
      een = (k >= 1 && k <= 9);
      ea  = (k == 0) ? 32'h0 : (k == 1) ? 32'h100 : (k == 2) ? 32'h200 :
            (k == 10) ? 32'h107 : 32'h100 + 32'(k) - 32'd2;
      drive(v, 32'h100 + 32'(k), 0, 32'h200);
      chk($sformatf("fair%0d mem_en", k),   32'(bus.mem_en_out),    32'(een));
      chk($sformatf("fair%0d mem_addr", k), bus.mem_addr_out,       ea);
      chk($sformatf("fair%0d overflow", k), 32'(bus.overflow_out),  32'h0);
      chk($sformatf("fair%0d ready", k),    32'(bus.req_ready_out),
          (k >= 2 && k <= 7) ? 32'h6 : 32'h7);
    end

    // reset with two reads in flight
    do_reset();
    drive(3'b011, 32'h50, 32'h51, 0);
    drive(3'b000, 0, 0, 0);
    drive(3'b000, 0, 0, 0);
    chk("inflight mem_en",   32'(bus.mem_en_out), 32'h1);
    chk("inflight mem_addr", bus.mem_addr_out,    32'h51);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 32'h0, 3'b000, 32'h0, 3'b111, 3'b000, 1'b0);
    @(negedge clk_in);
    rst_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk_in);
      #1;
      chk($sformatf("post_rst%0d resp_vld", k), 32'(bus.resp_valid_out), 32'h0);
      chk($sformatf("post_rst%0d mem_en", k),   32'(bus.mem_en_out),     32'h0);
      chk($sformatf("post_rst%0d resp_dat", k), bus.resp_data_out,       32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/graph_mem_arbiter.md
# graph_mem_arbiter

Shares one graph BRAM read port between the graph fetch unit's three independent read streams: position/vertex data, neighbor list, and row index. Each stream issues single-cycle request pulses, so every requester has a small pending queue. A round-robin scheduler grants one read per cycle, and a tag pipeline matched to the BRAM read latency routes each returned word back to the requester that issued it. It sits between the graph fetch unit's memory ports and the graph memory.

## Interface
- NUM_REQ, 3, number of requesters (0 = data, 1 = neighbor, 2 = row index)
- QDEPTH, 2, per-requester pending-queue depth (power of two, ≥2)
- READ_LAT, 2, BRAM read latency in cycles from mem_en_out to valid mem_data_in (≥1)
- clk_in  input  1  clock; all state on rising edge
- rst_in  input  1  asynchronous, active-low reset
- req_valid_in  input  NUM_REQ  per-requester single-cycle read request
- req_addr_in  input  32*NUM_REQ  flattened addresses; requester i at [32*i+31:32*i]
- req_ready_out  output  NUM_REQ  queue i not full (registered)
- resp_valid_out  output  NUM_REQ  one-hot; read data for requester i valid this cycle
- resp_data_out  output  32  returned word (registered)
- mem_en_out  output  1  BRAM read enable (registered)
- mem_addr_out  output  32  BRAM read address (registered)
- mem_data_in  input  32  BRAM read data, valid READ_LAT cycles after mem_en_out
- overflow_out  output  NUM_REQ  sticky; request dropped on full queue i
- busy_out  output  1  any queue non-empty or any read in flight

## Operation
- Reset values:
  - req_ready_out all 1.
  - resp_valid_out 0, resp_data_out 0.
  - mem_en_out 0, mem_addr_out 0.
  - overflow_out 0, busy_out 0.
  - Round-robin pointer at requester 0.
  - Queues empty; tag pipeline cleared.
- Enqueue: req_valid_in[i] writes req_addr_in slice i into queue i at the clock edge.
  - If queue i is full and is not granted that cycle, the request is dropped and overflow_out[i] is set. It clears only on reset.
  - Enqueue into a full queue that is granted the same cycle is accepted; it is not an overflow.
- Arbitration: each cycle, among non-empty queues, grant the first requester at or after the pointer, wrapping modulo NUM_REQ.
  - On a grant to i, the pointer moves to (i+1) mod NUM_REQ. With no grant, the pointer holds.
  - The granted queue head is dequeued and registered onto mem_addr_out, with mem_en_out = 1 the next cycle. mem_en_out = 0 when there is no grant; mem_addr_out holds its last value.
- Tag pipeline: a READ_LAT-deep shift register of {valid, requester index} records each grant.
  - When the entry arriving alongside valid mem_data_in is valid, resp_data_out <= mem_data_in and resp_valid_out <= one-hot(index) on the next edge. Otherwise resp_valid_out <= 0 and resp_data_out holds.
- Responses return in grant order. There is no backpressure on responses; requesters must accept the word in its cycle.
- busy_out is registered and reflects state after each edge.

## Timing
- Request pulse in cycle t; queue empty and requester wins: mem_en_out high in cycle t+1, resp_valid_out high in cycle t+2+READ_LAT (cycle t+4 at default).
- Throughput is one read per cycle in aggregate. With all queues non-empty, each requester is granted at least once every NUM_REQ cycles.
- req_ready_out updates the cycle after the enqueue/dequeue that changes occupancy.
- Reset asserted mid-operation: immediate (asynchronous) clear of all queues, in-flight tags, and outputs. Data returning from the BRAM after reset release is discarded.
- Arithmetic: queue pointers are $clog2(QDEPTH) bits and wrap naturally; the count is one bit wider. The round-robin pointer is $clog2(NUM_REQ) bits with explicit wrap at NUM_REQ-1 → 0.

## Configuration
- GRAPH_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest-index non-empty queue always wins and the round-robin pointer is removed. This favors position reads so vertex data completes before further neighbor prefetch.
- Undefined (default): round-robin as specified in Operation.

## Test plan
- Single request: req_valid_in = 3'b010, addr 0x10, BRAM returns 0xABCD → mem_en_out and mem_addr_out = 0x10 in cycle t+1; resp_valid_out = 3'b010 and resp_data_out = 0xABCD in cycle t+4.
- Simultaneous: all three requesters pulse in the same cycle with addrs 0x1/0x2/0x3 → mem_addr_out sequence 0x1, 0x2, 0x3 in consecutive cycles; responses one-hot 001, 010, 100 in order. With GRAPH_ARB_FIXED_PRIO_EN the order is the same.
- Fairness: requester 0 pulses every cycle, requester 2 pulses once → requester 2 is granted within 2 cycles; overflow_out[0] stays 0.
- Overflow: three back-to-back pulses to requester 1 while requesters 0 and 2 are saturated → third request dropped, overflow_out[1] = 1 and sticky; no response for the dropped address.
- Reset with 2 reads in flight: rst_in low for 1 cycle → all outputs 0 immediately; no resp_valid_out afterward despite BRAM data.
- Full-and-granted: queue 0 full, dequeued and enqueued in the same cycle → no overflow; the new address is serviced later.
